lsq_ooo: RTL

Parametrised load-store queue for the out-of-order core. It sits between dispatch, the AGU/LSU and the data-memory port, and holds DEPTH memory ops in program order in a circular buffer. It adds over the first-generation queue: a full/ready handshake, ROB-tag matching, age-correct store-to-load forwarding, conservative memory disambiguation, stores written to memory only at commit, and flush.

---
 rtl/lsq_pkg.sv | 32 +++
 rtl/lsq_ooo_if.sv | 55 +++++
 rtl/lsq_fwd_scan.sv | 28 ++
 rtl/lsq_ooo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types for the out-of-order load-store queue: entry state, entry record
// and the circular-buffer age helpers.
package lsq_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_WAIT_ADDR,
        ST_READY,
        ST_ISSUED,
        ST_DONE
    } lsq_state_e;

    typedef struct packed {
        logic              valid;
        logic              is_store;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        lsq_state_e        state;
    } lsq_entry_t;

    // Distance of a slot from the head, i.e. its position in program order.
    function automatic int lsq_age(int idx, int head, int depth);
        return (idx - head + depth) % depth;
    endfunction

    function automatic logic lsq_older(int a, int b, int head, int depth);
        return lsq_age(a, head, depth) < lsq_age(b, head, depth);
    endfunction
endpackage

// File: rtl/lsq_ooo_if.sv
// Dispatch, AGU, memory, CDB and commit signals of the load-store queue.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// source holds its payload stable while valid && !ready.
interface lsq_ooo_if #(parameter int DEPTH = 16);
    import lsq_pkg::*;
    localparam int PTR_W = $clog2(DEPTH);

    logic              flush;
    logic              dis_valid;
    logic              dis_ready;
    logic              dis_is_store;
    logic [TAG_W-1:0]  dis_tag;
    logic              agu_valid;
    logic [TAG_W-1:0]  agu_tag;
    logic [XLEN-1:0]   agu_addr;
    logic [XLEN-1:0]   agu_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [XLEN-1:0]   mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              mem_rsp_valid;
    logic [TAG_W-1:0]  mem_rsp_tag;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              ld_done_valid;
    logic [TAG_W-1:0]  ld_done_tag;
    logic [XLEN-1:0]   ld_done_data;
    logic              commit_valid;
    logic              commit_ready;
    logic              full;
    logic [PTR_W:0]    dbg_count;
    logic [PTR_W-1:0]  dbg_head;
    lsq_state_e        dbg_head_state;

    modport slave (
        input  flush, dis_valid, dis_is_store, dis_tag,
        input  agu_valid, agu_tag, agu_addr, agu_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
        input  commit_valid,
        output dis_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_tag,
        output ld_done_valid, ld_done_tag, ld_done_data, commit_ready, full,
        output dbg_count, dbg_head, dbg_head_state
    );

    modport master (
        output flush, dis_valid, dis_is_store, dis_tag,
        output agu_valid, agu_tag, agu_addr, agu_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
        output commit_valid,
        input  dis_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_tag,
        input  ld_done_valid, ld_done_tag, ld_done_data, commit_ready, full,
        input  dbg_count, dbg_head, dbg_head_state
    );
endinterface

// File: rtl/lsq_fwd_scan.sv
// Finds the youngest store older than the selected load that hits the same word;
// walks slots in program order so later (younger) hits override earlier ones.
module lsq_fwd_scan import lsq_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic [DEPTH-1:0]  st_known,
    input  logic [XLEN-3:0]   waddr [DEPTH],
    input  logic [XLEN-1:0]   sdata [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [PTR_W-1:0]  ld_idx,
    output logic              hit,
    output logic [XLEN-1:0]   data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] j;
            j = head + PTR_W'(i);
            if (lsq_older(int'(j), int'(ld_idx), int'(head), DEPTH) &&
                st_known[j] && (waddr[j] == waddr[ld_idx])) begin
                hit  = 1'b1;
                data = sdata[j];
            end
        end
    end
endmodule

// File: rtl/lsq_ooo.sv
// Out-of-order load-store queue: in-order circular buffer with ROB-tag CAMs,
// store-to-load forwarding, conservative disambiguation and commit-time stores.
module lsq_ooo import lsq_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    lsq_ooo_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    lsq_entry_t        ent [DEPTH];
    lsq_entry_t        head_ent;
    logic [PTR_W-1:0]  head, tail, sel_idx, ld_idx, rsp_idx, ld_lock_idx;
    logic [PTR_W:0]    count;
    logic              sel_valid, ld_lock_valid, rsp_hit, fwd_hit;
    logic              ld_cand, fwd_fire, ld_req, st_head_ok, st_req;
    logic              disp_fire, commit_fire;
    logic [XLEN-1:0]   fwd_data;
    logic [DEPTH-1:0]  st_known;
    logic [XLEN-3:0]   waddr [DEPTH];
    logic [XLEN-1:0]   sdata [DEPTH];

    assign head_ent      = ent[head];
    assign bus.dis_ready = (count != FULL_CNT);
    assign bus.full      = (count == FULL_CNT);
    assign disp_fire     = bus.dis_valid && bus.dis_ready;
    assign commit_fire   = bus.commit_valid && bus.commit_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_vec
        assign st_known[g] = ent[g].valid && ent[g].is_store && (ent[g].state == ST_DONE);
        assign waddr[g]    = ent[g].addr[XLEN-1:2];
        assign sdata[g]    = ent[g].data;
    end

    // Oldest READY load not shadowed by an older store whose address is unknown.
    always_comb begin
        logic blocked;
        blocked   = 1'b0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] j;
            j = head + PTR_W'(i);
            if (ent[j].valid) begin
                if (ent[j].is_store && ent[j].state == ST_WAIT_ADDR) begin
                    blocked = 1'b1;
                end else if (!ent[j].is_store && ent[j].state == ST_READY && !blocked && !sel_valid) begin
                    sel_valid = 1'b1;
                    sel_idx   = j;
                end
            end
        end
    end

    always_comb begin
        rsp_hit = 1'b0;
        rsp_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.mem_rsp_valid && ent[i].valid && ent[i].state == ST_ISSUED &&
                ent[i].tag == bus.mem_rsp_tag) begin
                rsp_hit = 1'b1;
                rsp_idx = PTR_W'(i);
            end
        end
    end

    lsq_fwd_scan #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
        .st_known (st_known),
        .waddr    (waddr),
        .sdata    (sdata),
        .head     (head),
        .ld_idx   (ld_idx),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    // A load request left waiting on mem_req_ready is locked so the port stays
    // stable; only an unlocked port lets a committing store take priority.
    assign ld_idx     = ld_lock_valid ? ld_lock_idx : sel_idx;
    assign ld_cand    = ld_lock_valid || sel_valid;
    assign st_head_ok = head_ent.valid && head_ent.is_store && (head_ent.state == ST_DONE) && !ld_lock_valid;
    assign st_req     = st_head_ok && bus.commit_valid;
    assign fwd_fire   = ld_cand && !ld_lock_valid && fwd_hit && !rsp_hit;
    assign ld_req     = ld_cand && (ld_lock_valid || !fwd_hit) && !st_req;

    assign bus.commit_ready = head_ent.valid && (head_ent.state == ST_DONE) &&
                              (head_ent.is_store ? (!ld_lock_valid && bus.mem_req_ready) : 1'b1);

    always_comb begin
        bus.mem_req_valid = st_req || ld_req;
        bus.mem_req_we    = st_req;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        bus.mem_req_tag   = '0;
        if (st_req) begin
            bus.mem_req_addr  = head_ent.addr;
            bus.mem_req_wdata = head_ent.data;
            bus.mem_req_tag   = head_ent.tag;
        end else if (ld_req) begin
            bus.mem_req_addr  = ent[ld_idx].addr;
            bus.mem_req_tag   = ent[ld_idx].tag;
        end
    end

    assign bus.dbg_count      = count;
    assign bus.dbg_head       = head;
    assign bus.dbg_head_state = head_ent.state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            ld_lock_valid     <= 1'b0;
            ld_lock_idx       <= '0;
            bus.ld_done_valid <= 1'b0;
            bus.ld_done_tag   <= '0;
            bus.ld_done_data  <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            ld_lock_valid     <= 1'b0;
            bus.ld_done_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.agu_valid && ent[i].valid && ent[i].state == ST_WAIT_ADDR &&
                    ent[i].tag == bus.agu_tag) begin
                    ent[i].addr  <= bus.agu_addr;
                    ent[i].data  <= bus.agu_data;
                    ent[i].state <= ent[i].is_store ? ST_DONE : ST_READY;
                end
            end
            if (rsp_hit)                    ent[rsp_idx].state <= ST_DONE;
            if (fwd_fire)                   ent[ld_idx].state  <= ST_DONE;
            if (ld_req && bus.mem_req_ready) ent[ld_idx].state <= ST_ISSUED;
            ld_lock_valid <= ld_req && !bus.mem_req_ready;
            ld_lock_idx   <= ld_idx;

            // The memory response owns the CDB slot; a competing forward retries.
            bus.ld_done_valid <= rsp_hit || fwd_fire;
            if (rsp_hit) begin
                bus.ld_done_tag  <= ent[rsp_idx].tag;
                bus.ld_done_data <= bus.mem_rsp_data;
            end else if (fwd_fire) begin
                bus.ld_done_tag  <= ent[ld_idx].tag;
                bus.ld_done_data <= fwd_data;
            end

            if (commit_fire) begin
                ent[head] <= '0;
                head      <= head + PTR_W'(1);
            end
            if (disp_fire) begin
                ent[tail] <= '{valid: 1'b1, is_store: bus.dis_is_store, tag: bus.dis_tag,
                               addr: '0, data: '0, state: ST_WAIT_ADDR};
                tail      <= tail + PTR_W'(1);
            end
            if (disp_fire && !commit_fire)      count <= count + (PTR_W+1)'(1);
            else if (!disp_fire && commit_fire) count <= count - (PTR_W+1)'(1);
        end
    end
endmodule
